// File: rtl/pe_network_interface_pkg.sv
// Shared definitions for the PE network interface.
//   FLIT_W          flit width in bits
//   VC_BIT          virtual-channel bit of a flit
//   X_HI/X_LO       signed X hop field
//   Y_HI/Y_LO       signed Y hop field
//   CNT_W           width of the saturating flit counters
//   inj_state_t     inject FSM state encoding
//   sat_inc()       saturating increment for the flit counters
package pe_network_interface_pkg;

  localparam int FLIT_W = 64;
  localparam int VC_BIT = 63;
  localparam int X_HI   = 55;
  localparam int X_LO   = 52;
  localparam int Y_HI   = 51;
  localparam int Y_LO   = 48;
  localparam int CNT_W  = 16;

  typedef enum logic {
    INJ_IDLE = 1'b0,
    INJ_HOLD = 1'b1
  } inj_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/nic_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   i_push/i_din write strobe and data (ignored while full)
//   i_pop        read strobe (ignored while empty)
//   o_dout       head entry; reads as zero while empty
//   o_full       no room for a push
//   o_empty      nothing to pop
module nic_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  // Gate the head so an empty FIFO never exposes stale storage.
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/pe_network_interface.sv
// Network interface between a processing element and its router port.
//   clk, reset                        clock, asynchronous active-low reset
//   polarity                          router VC window
//   cpu_tx_valid/ready/flit           PE -> NIC flits (injection FIFO)
//   cpu_rx_valid/ready/flit           NIC -> PE flits (ejection FIFO, FWFT)
//   nicso/nicro/nicdo                 inject handshake to the router
//   nicsi/nicri/nicdi                 eject handshake from the router
//   tx_count/rx_count                 saturating injected/ejected flit counts
//   misroute_err                      sticky: ejected flit had nonzero hops
//   dbg_inj_state                     inject FSM state, for observation
//
// Handshake rule for every valid/ready pair here: a transfer happens at a
// rising edge where both are high; the sender holds data stable while valid
// is high and not yet accepted, and ready never depends on same-cycle valid.
module pe_network_interface
  import pe_network_interface_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              cpu_tx_valid,
  output logic              cpu_tx_ready,
  input  logic [FLIT_W-1:0] cpu_tx_flit,
  output logic              cpu_rx_valid,
  input  logic              cpu_rx_ready,
  output logic [FLIT_W-1:0] cpu_rx_flit,
  output logic              nicso,
  input  logic              nicro,
  output logic [FLIT_W-1:0] nicdo,
  input  logic              nicsi,
  output logic              nicri,
  input  logic [FLIT_W-1:0] nicdi,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count,
  output logic              misroute_err,
  output inj_state_t        dbg_inj_state
);

  // Readies stay low through reset and rise on the first edge afterwards.
  logic              r_alive;
  inj_state_t        r_state;
  logic [FLIT_W-1:0] r_nicdo;
  logic [CNT_W-1:0]  r_tx_count;
  logic [CNT_W-1:0]  r_rx_count;
  logic              r_misroute;

  logic              w_inj_full;
  logic              w_inj_empty;
  logic [FLIT_W-1:0] w_inj_head;
  logic              w_inj_pop;
  logic              w_tx_push;
  logic              w_tx_done;

  logic              w_ej_full;
  logic              w_ej_empty;
  logic              w_rx_push;
  logic              w_rx_pop;
  logic              w_hops_nz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_alive <= 1'b0;
    else        r_alive <= 1'b1;
  end

  // ---------------- inject path ----------------
  assign cpu_tx_ready = r_alive && !w_inj_full;
  assign w_tx_push    = cpu_tx_valid && cpu_tx_ready;

  // The router only accepts a flit whose VC bit matches its current window.
  assign nicso     = (r_state == INJ_HOLD) && (polarity == r_nicdo[VC_BIT]);
  assign w_tx_done = nicso && nicro;
  // Load the output register from idle, or refill it in the same edge a
  // transfer completes so back-to-back flits need no bubble.
  assign w_inj_pop = !w_inj_empty && ((r_state == INJ_IDLE) || w_tx_done);

  nic_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_inj_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_tx_push),
    .i_din   (cpu_tx_flit),
    .i_pop   (w_inj_pop),
    .o_dout  (w_inj_head),
    .o_full  (w_inj_full),
    .o_empty (w_inj_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= INJ_IDLE;
      r_nicdo    <= '0;
      r_tx_count <= '0;
    end else begin
      case (r_state)
        INJ_IDLE: begin
          if (!w_inj_empty) begin
            r_nicdo <= w_inj_head;
            r_state <= INJ_HOLD;
          end
        end
        INJ_HOLD: begin
          if (w_tx_done) begin
            r_tx_count <= sat_inc(r_tx_count);
            if (!w_inj_empty) r_nicdo <= w_inj_head;
            else              r_state <= INJ_IDLE;
          end
        end
        default: r_state <= INJ_IDLE;
      endcase
    end
  end

  assign nicdo         = r_nicdo;
  assign tx_count      = r_tx_count;
  assign dbg_inj_state = r_state;

  // ---------------- eject path ----------------
  assign nicri        = r_alive && !w_ej_full;
  assign w_rx_push    = nicsi && nicri;
  assign cpu_rx_valid = !w_ej_empty;
  assign w_rx_pop     = cpu_rx_valid && cpu_rx_ready;
  // A flit arriving at its destination must have exhausted both hop counts.
  assign w_hops_nz    = (nicdi[X_HI:X_LO] != '0) || (nicdi[Y_HI:Y_LO] != '0);

  nic_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_ej_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_rx_push),
    .i_din   (nicdi),
    .i_pop   (w_rx_pop),
    .o_dout  (cpu_rx_flit),
    .o_full  (w_ej_full),
    .o_empty (w_ej_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_count <= '0;
      r_misroute <= 1'b0;
    end else if (w_rx_push) begin
      r_rx_count <= sat_inc(r_rx_count);
      if (w_hops_nz) r_misroute <= 1'b1;
    end
  end

  assign rx_count     = r_rx_count;
  assign misroute_err = r_misroute;

endmodule
